// File: rtl/cory_dmx8.sv
// -----------------------------------------------------------------------------
// cory_dmx8 -- 1-to-8 stream demultiplexer with a 2-entry in-order FIFO.
//
// Each accepted upstream beat is stored as {data, dest} and later presented
// only on the output port named by its dest field. Beats leave in arrival
// order, so a head beat stalled on one port holds back every later beat,
// including beats bound for other ports.
//
// Ports
//   clk                 sole clock, rising edge
//   reset               synchronous, active-high flush
//   i_a_v/i_a_d/i_a_s   upstream valid / data (N bits) / destination 0..7
//   o_a_r               upstream ready (registered occupancy < 2)
//   o_zK_v/o_zK_d       valid / data toward destination K (K = 0..7)
//   i_zK_r              ready from destination K
//   i_cnt_sel           selects the per-port transfer counter shown on o_cnt
//   i_cnt_clr           synchronous clear of all transfer counters
//   o_cnt               transfer count of port i_cnt_sel
//
// Build option
//   CORY_DMX8_CNT_EN    when defined, keeps eight saturating 16-bit counters
//                       of downstream transfers; otherwise o_cnt is tied to 0.
// -----------------------------------------------------------------------------
module cory_dmx8 #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_a_v,
    input  logic [N-1:0] i_a_d,
    input  logic [2:0]   i_a_s,
    output logic         o_a_r,
    output logic         o_z0_v,
    output logic         o_z1_v,
    output logic         o_z2_v,
    output logic         o_z3_v,
    output logic         o_z4_v,
    output logic         o_z5_v,
    output logic         o_z6_v,
    output logic         o_z7_v,
    output logic [N-1:0] o_z0_d,
    output logic [N-1:0] o_z1_d,
    output logic [N-1:0] o_z2_d,
    output logic [N-1:0] o_z3_d,
    output logic [N-1:0] o_z4_d,
    output logic [N-1:0] o_z5_d,
    output logic [N-1:0] o_z6_d,
    output logic [N-1:0] o_z7_d,
    input  logic         i_z0_r,
    input  logic         i_z1_r,
    input  logic         i_z2_r,
    input  logic         i_z3_r,
    input  logic         i_z4_r,
    input  logic         i_z5_r,
    input  logic         i_z6_r,
    input  logic         i_z7_r,
    input  logic [2:0]   i_cnt_sel,
    input  logic         i_cnt_clr,
    output logic [15:0]  o_cnt
);

    typedef struct packed {
        logic [N-1:0] d;
        logic [2:0]   s;
    } entry_t;

    entry_t     mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] occ;

    entry_t     head;
    logic [7:0] z_v;
    logic [7:0] z_r;
    logic       push;
    logic       pop;

    assign z_r  = {i_z7_r, i_z6_r, i_z5_r, i_z4_r, i_z3_r, i_z2_r, i_z1_r, i_z0_r};
    assign head = mem[rd_ptr];

    // Ready comes from registered occupancy only, so downstream ready never
    // reaches o_a_r combinationally; a full FIFO refuses even on a same-cycle pop.
    assign o_a_r = (occ < 2'd2);
    assign push  = i_a_v && o_a_r;
    // z_v is zero for every port but the head's, so ready on an idle port is ignored.
    assign pop   = |(z_v & z_r);

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        z_v = '0;
        if (occ != 2'd0) begin
            z_v[head.s] = 1'b1;
        end
    end

    assign {o_z7_v, o_z6_v, o_z5_v, o_z4_v, o_z3_v, o_z2_v, o_z1_v, o_z0_v} = z_v;

    // Data is broadcast from the head; only the valid port's copy is meaningful.
    assign o_z0_d = head.d;
    assign o_z1_d = head.d;
    assign o_z2_d = head.d;
    assign o_z3_d = head.d;
    assign o_z4_d = head.d;
    assign o_z5_d = head.d;
    assign o_z6_d = head.d;
    assign o_z7_d = head.d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ    <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // NOTE: the storage array has no reset; occupancy alone says which entries
    // are live, so stale contents are never presented as valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{d: i_a_d, s: i_a_s};
        end
    end

`ifdef CORY_DMX8_CNT_EN
    logic [15:0] cnt [8];

    // Clear (reset or i_cnt_clr) wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (reset || i_cnt_clr) begin
            for (int k = 0; k < 8; k++) cnt[k] <= 16'd0;
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (z_v[k] && z_r[k] && (cnt[k] != 16'hFFFF)) begin
                    cnt[k] <= cnt[k] + 16'd1;
                end
            end
        end
    end

    assign o_cnt = cnt[i_cnt_sel];
`else
    logic unused_cnt_ctrl;
    assign unused_cnt_ctrl = ^{i_cnt_sel, i_cnt_clr};
    assign o_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_cory_dmx8.sv
// -----------------------------------------------------------------------------
// tb_cory_dmx8 -- directed self-checking bench for cory_dmx8 (N = 8).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
// -----------------------------------------------------------------------------
module tb_cory_dmx8;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_v;
    logic [7:0]  a_d;
    logic [2:0]  a_s;
    logic        a_r;
    logic [7:0]  z_v;
    logic [7:0]  z_d [8];
    logic [7:0]  z_r;
    logic [2:0]  cnt_sel;
    logic        cnt_clr;
    logic [15:0] cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cory_dmx8 #(.N(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_a_v     (a_v),
        .i_a_d     (a_d),
        .i_a_s     (a_s),
        .o_a_r     (a_r),
        .o_z0_v    (z_v[0]),
        .o_z1_v    (z_v[1]),
        .o_z2_v    (z_v[2]),
        .o_z3_v    (z_v[3]),
        .o_z4_v    (z_v[4]),
        .o_z5_v    (z_v[5]),
        .o_z6_v    (z_v[6]),
        .o_z7_v    (z_v[7]),
        .o_z0_d    (z_d[0]),
        .o_z1_d    (z_d[1]),
        .o_z2_d    (z_d[2]),
        .o_z3_d    (z_d[3]),
        .o_z4_d    (z_d[4]),
        .o_z5_d    (z_d[5]),
        .o_z6_d    (z_d[6]),
        .o_z7_d    (z_d[7]),
        .i_z0_r    (z_r[0]),
        .i_z1_r    (z_r[1]),
        .i_z2_r    (z_r[2]),
        .i_z3_r    (z_r[3]),
        .i_z4_r    (z_r[4]),
        .i_z5_r    (z_r[5]),
        .i_z6_r    (z_r[6]),
        .i_z7_r    (z_r[7]),
        .i_cnt_sel (cnt_sel),
        .i_cnt_clr (cnt_clr),
        .o_cnt     (cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        a_v     = 1'b0;
        a_d     = 8'h00;
        a_s     = 3'd0;
        z_r     = 8'hFF;
        cnt_sel = 3'd0;
        cnt_clr = 1'b0;
        tick(2);
        reset = 1'b0;

        // Reset state
        check("rst_a_r", a_r, 1);
        check("rst_z_v", z_v, 0);
        check("rst_cnt", cnt, 0);

        // Single beat to port 5, one cycle latency
        a_v = 1'b1; a_s = 3'd5; a_d = 8'hA5;
        tick();
        a_v = 1'b0; a_d = 8'h00; a_s = 3'd0;
        check("one_z_v", z_v, 8'b0010_0000);
        check("one_z5_d", z_d[5], 8'hA5);
        tick();
        check("one_drain_z_v", z_v, 0);
        check("one_drain_a_r", a_r, 1);

        // Back-to-back beats to ports 0..7
        for (int k = 0; k < 8; k++) begin
            a_v = 1'b1; a_s = 3'(k); a_d = 8'(8'h10 + k);
            tick();
            check($sformatf("b2b_z_v_%0d", k), z_v, 32'(1 << k));
            check($sformatf("b2b_z_d_%0d", k), z_d[k], 32'(8'h10 + k));
            check($sformatf("b2b_a_r_%0d", k), a_r, 1);
        end
        a_v = 1'b0;
        tick();
        check("b2b_end_z_v", z_v, 0);

        // Head-of-line blocking on port 3
        z_r = 8'b1111_0111;
        a_v = 1'b1; a_s = 3'd3; a_d = 8'h33;
        tick();
        check("hol_1_z_v", z_v, 8'b0000_1000);
        check("hol_1_a_r", a_r, 1);
        a_s = 3'd6; a_d = 8'h61;
        tick();
        check("hol_2_z_v", z_v, 8'b0000_1000);
        check("hol_2_a_r", a_r, 0);
        a_s = 3'd6; a_d = 8'h62;
        tick(2);
        check("hol_stall_z_v", z_v, 8'b0000_1000);
        check("hol_stall_z3_d", z_d[3], 8'h33);
        check("hol_stall_a_r", a_r, 0);
        z_r = 8'hFF;
        tick();
        check("hol_pop_z_v", z_v, 8'b0100_0000);
        check("hol_pop_z6_d", z_d[6], 8'h61);
        check("hol_pop_a_r", a_r, 1);
        tick();
        a_v = 1'b0;
        check("hol_third_z_v", z_v, 8'b0100_0000);
        check("hol_third_z6_d", z_d[6], 8'h62);
        tick();
        check("hol_end_z_v", z_v, 0);

        // Full FIFO stalled on port 2 keeps data stable
        z_r = 8'b1111_1011;
        a_v = 1'b1; a_s = 3'd2; a_d = 8'h5A;
        tick();
        a_d = 8'h77;
        tick();
        a_v = 1'b0; a_d = 8'hFF; a_s = 3'd7;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("full_z_v_%0d", i), z_v, 8'b0000_0100);
            check($sformatf("full_z2_d_%0d", i), z_d[2], 8'h5A);
            check($sformatf("full_a_r_%0d", i), a_r, 0);
            tick();
        end

        // Reset while full, with a competing upstream beat and downstream ready
        reset = 1'b1; z_r = 8'hFF;
        a_v = 1'b1; a_s = 3'd2; a_d = 8'hEE;
        tick();
        reset = 1'b0; a_v = 1'b0;
        check("flush_z_v", z_v, 0);
        check("flush_a_r", a_r, 1);
        check("flush_cnt", cnt, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("flush_after_z_v_%0d", i), z_v, 0);
        end

`ifdef CORY_DMX8_CNT_EN
        // Counter on port 4 counts one downstream transfer
        cnt_sel = 3'd4;
        a_v = 1'b1; a_s = 3'd4; a_d = 8'h44;
        tick();
        a_v = 1'b0;
        check("cnt4_before", cnt, 0);
        tick();
        check("cnt4_after", cnt, 1);

        // Saturation on port 1, then clear beats a same-cycle increment
        cnt_sel = 3'd1;
        a_v = 1'b1; a_s = 3'd1; a_d = 8'h11;
        tick(70000);
        check("cnt1_sat", cnt, 16'hFFFF);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("cnt1_clr", cnt, 0);
        a_v = 1'b0;
        cnt_sel = 3'd4;
        check("cnt4_cleared", cnt, 0);
`else
        // Counters absent: o_cnt stays 0 whatever the controls do
        cnt_sel = 3'd1;
        a_v = 1'b1; a_s = 3'd1; a_d = 8'h11;
        tick(3);
        a_v = 1'b0;
        check("nocnt_sel1", cnt, 0);
        cnt_clr = 1'b1; cnt_sel = 3'd7;
        tick();
        cnt_clr = 1'b0;
        check("nocnt_clr", cnt, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cory_dmx8.md
CORY_DMX8 -- requirements
Module: cory_dmx8

Interface
REQ-001 SHALL provide parameter N, default 8, meaning the data width in bits.
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL provide port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL provide port i_a_v  input  1  upstream valid.
REQ-005 SHALL provide port i_a_d  input  N  upstream data.
REQ-006 SHALL provide port i_a_s  input  3  destination port index, 0..7.
REQ-007 SHALL provide port o_a_r  output  1  upstream ready.
REQ-008 SHALL provide ports o_zK_v  output  1, for K=0..7  valid toward destination K.
REQ-009 SHALL provide ports o_zK_d  output  N, for K=0..7  data toward destination K.
REQ-010 SHALL provide ports i_zK_r  input  1, for K=0..7  ready from destination K.
REQ-011 SHALL provide port i_cnt_sel  input  3  selects which per-port transfer counter appears on o_cnt.
REQ-012 SHALL provide port i_cnt_clr  input  1  synchronous clear of all transfer counters.
REQ-013 SHALL provide port o_cnt  output  16  transfer count of port i_cnt_sel.

Function
REQ-014 SHALL route each accepted upstream beat to exactly one output port, the one given by i_a_s, and never to any other port.
REQ-015 SHALL count an upstream transfer only in a cycle where i_a_v=1 and o_a_r=1.
REQ-016 SHALL count a downstream transfer on port K only in a cycle where o_zK_v=1 and i_zK_r=1.
REQ-017 SHALL hold accepted beats, each stored as the pair {d,s}, in a 2-entry in-order FIFO.
REQ-018 SHALL drive o_a_r = 1 exactly when the FIFO holds fewer than 2 entries.
REQ-019 SHALL derive o_a_r from registered occupancy only, with no combinational path from any i_zK_r.
REQ-020 SHALL drive o_zK_v = 1 exactly when the FIFO is non-empty and the head entry's s equals K; at most one o_zK_v SHALL be high in any cycle.
REQ-021 SHALL drive all eight o_zK_d from the head entry's data.
REQ-022 SHALL hold each valid port's o_zK_d stable until the transfer completes.
REQ-023 SHALL have a latency of 1 cycle: a beat accepted at edge t is presented on its port from cycle t+1.
REQ-024 SHALL sustain 1 beat/cycle when the destination ready is held high.
REQ-025 SHALL support push and pop in the same cycle at occupancy 1, leaving occupancy at 1.
REQ-026 SHALL, at occupancy 0 with a push, reach occupancy 1 and present the new beat in the next cycle.
REQ-027 SHALL enforce strict order: a head stalled on port K blocks all later beats, including beats for other ports (head-of-line blocking is intended).
REQ-028 SHALL ignore i_zK_r whenever o_zK_v=0.
REQ-029 SHALL ignore i_a_d and i_a_s whenever no upstream transfer occurs.
REQ-030 SHALL implement the FIFO pointers as 1-bit values that wrap 1->0.
REQ-031 SHALL implement occupancy as a 2-bit value in the range 0..2.

Reset
REQ-032 SHALL, while reset=1 at a clock edge, flush the FIFO: occupancy 0 and both pointers 0.
REQ-033 SHALL, while reset=1 at a clock edge, clear all transfer counters to 0.
REQ-034 SHALL drive these values in the cycle after reset: o_a_r=1, all o_zK_v=0, o_cnt=0; o_zK_d is don't-care.
REQ-035 SHALL discard any beats pending at a reset asserted mid-operation; none is delivered afterward.
REQ-036 SHALL give reset priority over any simultaneous handshake in the same cycle.

Configuration
REQ-037 SHALL, when macro CORY_DMX8_CNT_EN is defined, keep eight 16-bit per-port counters of downstream transfers.
REQ-038 SHALL, with CORY_DMX8_CNT_EN defined, saturate each counter at 16'hFFFF.
REQ-039 SHALL, with CORY_DMX8_CNT_EN defined, clear all counters when i_cnt_clr=1; clear wins over a same-cycle increment.
REQ-040 SHALL, with CORY_DMX8_CNT_EN defined, drive o_cnt combinationally from the counter selected by i_cnt_sel.
REQ-041 SHALL, when CORY_DMX8_CNT_EN is undefined, instantiate no counter logic, tie o_cnt to 0, and ignore i_cnt_sel and i_cnt_clr; the port list is identical in both builds.

Verification
REQ-042 SHALL cover: reset, then i_a_v=1 with s=5 and d=8'hA5, and all ready high -> o_z5_v=1 with d=8'hA5 one cycle later, and no other o_zK_v high.
REQ-043 SHALL cover: all ready high, back-to-back beats with s=0..7 and d=0x10..0x17 -> each port K sees exactly one beat 0x10+K, in order, 8 beats in 8 consecutive cycles.
REQ-044 SHALL cover: i_z3_r=0 while beats are sent with s=3,6,6 -> o_a_r drops after 2 accepts; o_z6_v stays 0 until i_z3_r=1; the third beat is accepted only after the first pop.
REQ-045 SHALL cover: FIFO full with o_z2_d=8'h5A and i_z2_r=0 for 10 cycles -> o_z2_v=1 and o_z2_d=8'h5A stable throughout.
REQ-046 SHALL cover: reset asserted for 1 cycle while occupancy is 2 -> next cycle all o_zK_v=0 and o_a_r=1, and the flushed beats never appear.
REQ-047 SHALL cover, with CORY_DMX8_CNT_EN defined: 70000 transfers on port 1 -> o_cnt=16'hFFFF at i_cnt_sel=1; then i_cnt_clr=1 together with a port-1 transfer -> o_cnt=0.
